// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg
//   Shared constants for the debug-build CPU clock controller.
//   The state encoding is exported so the display and debug logic can
//   decode cpu_clk_ctrl.state_o without duplicating the numbers.
package cpu_dbg_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_STEP = 2'd1;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd2;
  localparam logic [STATE_W-1:0] ST_HALT = 2'd3;

endpackage

// File: rtl/cpu_clk_ctrl_key_debounce.sv
// key_debounce
//   Two-flop synchronizer plus debounce counter for an active-low push
//   button. The debounced level only changes after DEBOUNCE_CYCLES
//   consecutive synchronized samples disagree with it; a press pulse is
//   produced for the released->pressed (1->0) transition only.
//
// Ports:
//   clk      in   board clock
//   rst      in   asynchronous active-low reset
//   key_n_i  in   raw button, active-low, asynchronous to clk
//   level_o  out  debounced key level (1 = released)
//   press_o  out  one-clk pulse, registered, on each debounced press
module key_debounce
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  // Wide enough to hold DEBOUNCE_CYCLES itself.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      // The increment that would reach DEBOUNCE_CYCLES flips the level
      // instead, so the counter never actually stores that value.
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl
//   Produces the slow CPU clock for the FPGA debug build. In single-step
//   mode every debounced button press issues one tick; in free-run mode a
//   tick is issued every DIV clk cycles. A halt request from the core
//   freezes ticking until a press arrives with the request deasserted.
//   Each tick raises cpu_clk_o for HIGH_CYCLES cycles and bumps the
//   32-bit tick counter.
//
// Ports:
//   clk          in   board clock
//   rst          in   asynchronous active-low reset
//   key_n        in   step button, active-low, asynchronous
//   mode_run     in   1 = free-run, 0 = single-step, asynchronous
//   halt_i       in   core halt request, synchronous level
//   cpu_clk_o    out  registered CPU clock
//   tick_o       out  one-clk pulse with each cpu_clk_o rising edge
//   cycle_cnt_o  out  ticks issued since reset (wraps)
//   state_o      out  FSM state (see cpu_dbg_pkg)
module cpu_clk_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned DIV             = 25000000,
  parameter int unsigned HIGH_CYCLES     = 12500000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_n,
  input  logic        mode_run,
  input  logic        halt_i,
  output logic        cpu_clk_o,
  output logic        tick_o,
  output logic [31:0] cycle_cnt_o,
  output logic [1:0]  state_o
);

  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned HI_W  = $clog2(HIGH_CYCLES + 1);

  logic               key_press;
  logic               key_level_unused;  // level is exported for debug taps only

  logic               mode_sync1_q;
  logic               mode_sync2_q;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [DIV_W-1:0]   div_cnt_q;
  logic [DIV_W-1:0]   div_cnt_d;
  logic [HI_W-1:0]    high_cnt_q;
  logic [HI_W-1:0]    high_cnt_d;
  logic               cpu_clk_q;
  logic               cpu_clk_d;
  logic               tick_q;
  logic               tick_d;
  logic [31:0]        cycle_cnt_q;
  logic [31:0]        cycle_cnt_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_n),
    .level_o (key_level_unused),
    .press_o (key_press)
  );

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    tick_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = mode_sync2_q ? ST_RUN : ST_STEP;
      end
      ST_STEP: begin
        if (halt_i) begin
          state_d = ST_HALT;
        end else if (mode_sync2_q) begin
          state_d   = ST_RUN;
          div_cnt_d = '0;
        end else if (key_press && !cpu_clk_q) begin
          // A press during a high phase is dropped, not queued.
          tick_d = 1'b1;
        end
      end
      ST_RUN: begin
        // Halt has priority over both the mode switch and a due tick.
        if (halt_i) begin
          state_d   = ST_HALT;
          div_cnt_d = '0;
        end else if (!mode_sync2_q) begin
          state_d   = ST_STEP;
          div_cnt_d = '0;
        end else begin
          tick_d    = (div_cnt_q == '0);
          div_cnt_d = (div_cnt_q == DIV_W'(DIV - 1)) ? '0 : div_cnt_q + DIV_W'(1);
        end
      end
      ST_HALT: begin
        if (key_press && !halt_i) begin
          state_d   = mode_sync2_q ? ST_RUN : ST_STEP;
          div_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // High phase: load HIGH_CYCLES-1 with the tick and count down; the
    // clock drops on the cycle after the counter has reached zero.
    cpu_clk_d  = cpu_clk_q;
    high_cnt_d = high_cnt_q;
    if (tick_d) begin
      cpu_clk_d  = 1'b1;
      high_cnt_d = HI_W'(HIGH_CYCLES - 1);
    end else if (cpu_clk_q) begin
      if (high_cnt_q == '0) begin
        cpu_clk_d = 1'b0;
      end else begin
        high_cnt_d = high_cnt_q - HI_W'(1);
      end
    end

    cycle_cnt_d = tick_d ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_sync1_q <= 1'b0;
      mode_sync2_q <= 1'b0;
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      high_cnt_q   <= '0;
      cpu_clk_q    <= 1'b0;
      tick_q       <= 1'b0;
      cycle_cnt_q  <= '0;
    end else begin
      mode_sync1_q <= mode_run;
      mode_sync2_q <= mode_sync1_q;
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      high_cnt_q   <= high_cnt_d;
      cpu_clk_q    <= cpu_clk_d;
      tick_q       <= tick_d;
      cycle_cnt_q  <= cycle_cnt_d;
    end
  end

  assign cpu_clk_o   = cpu_clk_q;
  assign tick_o      = tick_q;
  assign cycle_cnt_o = cycle_cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl
//   Directed bench for cpu_clk_ctrl with DIV=4, HIGH_CYCLES=2,
//   DEBOUNCE_CYCLES=3. Inputs change 1 time unit after a rising edge and
//   outputs are sampled at the same point.
module tb_cpu_clk_ctrl;
  import cpu_dbg_pkg::*;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        key_n    = 1'b1;
  logic        mode_run = 1'b0;
  logic        halt_i   = 1'b0;
  logic        cpu_clk_o;
  logic        tick_o;
  logic [31:0] cycle_cnt_o;
  logic [1:0]  state_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(
    .DIV            (4),
    .HIGH_CYCLES    (2),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .mode_run   (mode_run),
    .halt_i     (halt_i),
    .cpu_clk_o  (cpu_clk_o),
    .tick_o     (tick_o),
    .cycle_cnt_o(cycle_cnt_o),
    .state_o    (state_o)
  );

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (cpu_clk_o !== 1'b0) begin errors++; $display("FAIL reset_cpu_clk: got %0b expected 0", cpu_clk_o); end
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b expected 0", tick_o); end
    checks++; if (cycle_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0h expected 0", cycle_cnt_o); end
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_o, ST_IDLE); end
    edge1();
    rst = 1'b1;
    #1;
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL release_idle: got %0d expected %0d", state_o, ST_IDLE); end
    edge1();
    checks++; if (state_o !== ST_STEP) begin errors++; $display("FAIL idle_to_step: got %0d expected %0d", state_o, ST_STEP); end
    $display("test_reset: state=%0d cnt=%0d", state_o, cycle_cnt_o);
  endtask

  task automatic test_step_press();
    int n_tick = 0;
    int tick_at = 0;
    int hi = 0;
    key_n = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      edge1();
      if (tick_o) begin
        n_tick++;
        if (tick_at == 0) tick_at = e;
      end
      if (cpu_clk_o) hi++;
    end
    key_n = 1'b1;
    repeat (8) edge1();
    checks++; if (n_tick !== 1) begin errors++; $display("FAIL step_tick_count: got %0d expected 1", n_tick); end
    checks++; if (tick_at !== 6) begin errors++; $display("FAIL step_latency: got edge %0d expected edge 6", tick_at); end
    checks++; if (hi !== 2) begin errors++; $display("FAIL step_high_len: got %0d expected 2", hi); end
    checks++; if (cycle_cnt_o !== 32'd1) begin errors++; $display("FAIL step_cnt: got %0d expected 1", cycle_cnt_o); end
    checks++; if (state_o !== ST_STEP) begin errors++; $display("FAIL step_state: got %0d expected %0d", state_o, ST_STEP); end
    $display("test_step_press: ticks=%0d at edge %0d high=%0d cnt=%0d", n_tick, tick_at, hi, cycle_cnt_o);
  endtask

  task automatic test_glitch_and_presses();
    int n_tick = 0;
    key_n = 1'b0;
    repeat (2) edge1();
    key_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      edge1();
      if (tick_o) n_tick++;
    end
    checks++; if (n_tick !== 0) begin errors++; $display("FAIL glitch_ticks: got %0d expected 0", n_tick); end
    checks++; if (cycle_cnt_o !== 32'd1) begin errors++; $display("FAIL glitch_cnt: got %0d expected 1", cycle_cnt_o); end
    $display("test_glitch: ticks=%0d cnt=%0d", n_tick, cycle_cnt_o);
    n_tick = 0;
    for (int p = 0; p < 3; p++) begin
      key_n = 1'b0;
      for (int e = 0; e < 6; e++) begin
        edge1();
        if (tick_o) n_tick++;
      end
      key_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
        edge1();
        if (tick_o) n_tick++;
      end
      $display("press %0d: cnt=%0d", p, cycle_cnt_o);
    end
    checks++; if (n_tick !== 3) begin errors++; $display("FAIL presses_ticks: got %0d expected 3", n_tick); end
    checks++; if (cycle_cnt_o !== 32'd4) begin errors++; $display("FAIL presses_cnt: got %0d expected 4", cycle_cnt_o); end
  endtask

  task automatic test_run();
    int n_tick = 0;
    int first = 0;
    logic [15:0] pat = '0;
    mode_run = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      edge1();
      if (tick_o) begin
        n_tick++;
        if (first == 0) first = e;
      end
      if (e >= 4 && e <= 19) pat[e-4] = cpu_clk_o;
    end
    checks++; if (state_o !== ST_RUN) begin errors++; $display("FAIL run_state: got %0d expected %0d", state_o, ST_RUN); end
    checks++; if (first !== 4) begin errors++; $display("FAIL run_first_tick: got edge %0d expected edge 4", first); end
    checks++; if (n_tick !== 5) begin errors++; $display("FAIL run_tick_count: got %0d expected 5", n_tick); end
    checks++; if (pat !== 16'h3333) begin errors++; $display("FAIL run_clk_pattern: got %04h expected 3333", pat); end
    checks++; if (cycle_cnt_o !== 32'd9) begin errors++; $display("FAIL run_cnt: got %0d expected 9", cycle_cnt_o); end
    $display("test_run: ticks=%0d first=%0d pattern=%04h cnt=%0d", n_tick, first, pat, cycle_cnt_o);
  endtask

  task automatic test_halt();
    int n_tick = 0;
    int first = 0;
    logic [1:0] st6 = '0;
    // The next tick is decided in the cycle after the third following edge.
    repeat (3) edge1();
    halt_i = 1'b1;
    edge1();
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL halt_wins_tick: got %0b expected 0", tick_o); end
    checks++; if (state_o !== ST_HALT) begin errors++; $display("FAIL halt_state: got %0d expected %0d", state_o, ST_HALT); end
    checks++; if (cycle_cnt_o !== 32'd9) begin errors++; $display("FAIL halt_cnt: got %0d expected 9", cycle_cnt_o); end
    key_n = 1'b0;
    for (int e = 0; e < 8; e++) begin
      edge1();
      if (tick_o) n_tick++;
    end
    key_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      edge1();
      if (tick_o) n_tick++;
    end
    checks++; if (state_o !== ST_HALT) begin errors++; $display("FAIL halt_press_held: got %0d expected %0d", state_o, ST_HALT); end
    checks++; if (n_tick !== 0) begin errors++; $display("FAIL halt_no_ticks: got %0d expected 0", n_tick); end
    $display("test_halt: state=%0d ticks=%0d", state_o, n_tick);
    halt_i = 1'b0;
    edge1();
    key_n = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      edge1();
      if (tick_o && first == 0) first = e;
      if (e == 6) st6 = state_o;
    end
    key_n = 1'b1;
    checks++; if (st6 !== ST_RUN) begin errors++; $display("FAIL halt_exit_state: got %0d expected %0d", st6, ST_RUN); end
    checks++; if (first !== 7) begin errors++; $display("FAIL halt_resume_tick: got edge %0d expected edge 7", first); end
    checks++; if (cycle_cnt_o !== 32'd10) begin errors++; $display("FAIL halt_resume_cnt: got %0d expected 10", cycle_cnt_o); end
    $display("test_halt_exit: state=%0d first_tick=%0d cnt=%0d", st6, first, cycle_cnt_o);
  endtask

  task automatic test_wrap();
    int n_tick = 0;
    mode_run = 1'b0;
    repeat (12) edge1();
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt_q;
    #1;
    checks++; if (cycle_cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %0h expected ffffffff", cycle_cnt_o); end
    key_n = 1'b0;
    for (int e = 0; e < 8; e++) begin
      edge1();
      if (tick_o) n_tick++;
    end
    key_n = 1'b1;
    repeat (8) edge1();
    checks++; if (n_tick !== 1) begin errors++; $display("FAIL wrap_ticks: got %0d expected 1", n_tick); end
    checks++; if (cycle_cnt_o !== 32'd0) begin errors++; $display("FAIL wrap_cnt: got %0h expected 0", cycle_cnt_o); end
    $display("test_wrap: ticks=%0d cnt=%0h", n_tick, cycle_cnt_o);
  endtask

  task automatic test_reset_mid_high();
    key_n = 1'b0;
    repeat (6) edge1();
    checks++; if (cpu_clk_o !== 1'b1) begin errors++; $display("FAIL midhigh_setup: got %0b expected 1", cpu_clk_o); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (cpu_clk_o !== 1'b0) begin errors++; $display("FAIL async_cpu_clk: got %0b expected 0", cpu_clk_o); end
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL async_tick: got %0b expected 0", tick_o); end
    checks++; if (cycle_cnt_o !== 32'd0) begin errors++; $display("FAIL async_cnt: got %0h expected 0", cycle_cnt_o); end
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL async_state: got %0d expected %0d", state_o, ST_IDLE); end
    key_n = 1'b1;
    edge1();
    rst = 1'b1;
    #1;
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL rerelease_idle: got %0d expected %0d", state_o, ST_IDLE); end
    edge1();
    checks++; if (state_o !== ST_STEP) begin errors++; $display("FAIL rerelease_step: got %0d expected %0d", state_o, ST_STEP); end
    $display("test_reset_mid_high: state after release=%0d", state_o);
    mode_run = 1'b1;
    rst = 1'b0;
    edge1();
    rst = 1'b1;
    edge1();
    checks++; if (state_o !== ST_STEP) begin errors++; $display("FAIL run_reset_first: got %0d expected %0d", state_o, ST_STEP); end
    repeat (2) edge1();
    checks++; if (state_o !== ST_RUN) begin errors++; $display("FAIL run_reset_run: got %0d expected %0d", state_o, ST_RUN); end
    edge1();
    checks++; if (tick_o !== 1'b1) begin errors++; $display("FAIL run_reset_tick: got %0b expected 1", tick_o); end
    $display("test_reset_run: state=%0d tick=%0b cnt=%0d", state_o, tick_o, cycle_cnt_o);
  endtask

  initial begin
    test_reset();
    test_step_press();
    test_glitch_and_presses();
    test_run();
    test_halt();
    test_wrap();
    test_reset_mid_high();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
